// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MIPS-style mult/div unit owning the HI/LO registers.
// One bit per cycle for 32 cycles, then a two-cycle sign-fixup/writeback phase.
module muldiv_ctrl (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_Start,
   input  logic [1:0]  i_Op,
   input  logic [31:0] i_A,
   input  logic [31:0] i_B,
   input  logic        i_Cancel,
   input  logic        i_HiLoRead,
   input  logic        i_WrHi,
   input  logic        i_WrLo,
   input  logic [31:0] i_WrData,
   output logic [31:0] o_Hi,
   output logic [31:0] o_Lo,
   output logic        o_Busy,
   output logic        o_Stall,
   output logic        o_Done,
   output logic        o_DivZero
);
   localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2;
   logic [1:0]  state;
   logic [4:0]  cnt;
   logic        isDiv, signA, signB, zeroPend;
   logic [31:0] aReg, bReg, aMag, bMag;
   logic [63:0] acc, calcNext, fixNext;
   logic [32:0] mulSum, divTrial;
   logic        isSigned, zeroDiv;
   always_comb begin
      isSigned = ~i_Op[0];
      zeroDiv  = i_Op[1] & (i_B == 32'd0);
      aMag     = (isSigned & i_A[31]) ? -i_A : i_A;
      bMag     = (isSigned & i_B[31]) ? -i_B : i_B;
      mulSum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, aReg} : 33'd0);
      divTrial = {acc[63:32], acc[31]} - {1'b0, bReg};
      // acc holds {product} for mult, {remainder, quotient/dividend} for div
      calcNext = isDiv ? (divTrial[32] ? {acc[62:0], 1'b0} : {divTrial[31:0], acc[30:0], 1'b1})
                       : {mulSum, acc[31:1]};
      fixNext  = isDiv ? {signA ? -acc[63:32] : acc[63:32], (signA ^ signB) ? -acc[31:0] : acc[31:0]}
                       : ((signA ^ signB) ? -acc : acc);
      o_Busy   = state != IDLE;
      o_Stall  = o_Busy & (i_HiLoRead | i_Start | i_WrHi | i_WrLo);
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         cnt <= 5'd0;
         isDiv <= 1'b0;
         signA <= 1'b0;
         signB <= 1'b0;
         zeroPend <= 1'b0;
         aReg <= 32'd0;
         bReg <= 32'd0;
         acc <= 64'd0;
         o_Hi <= 32'd0;
         o_Lo <= 32'd0;
         o_Done <= 1'b0;
         o_DivZero <= 1'b0;
      end else begin
         o_Done <= 1'b0;
         o_DivZero <= 1'b0;
         if (state == IDLE) begin
            if (i_WrHi) o_Hi <= i_WrData;
            if (i_WrLo) o_Lo <= i_WrData;
            if (i_Start & ~i_Cancel) begin
               aReg <= aMag;
               bReg <= bMag;
               isDiv <= i_Op[1];
               cnt <= 5'd0;
               zeroPend <= zeroDiv;
               signA <= isSigned & i_A[31] & ~zeroDiv;
               signB <= isSigned & i_B[31] & ~zeroDiv;
               acc <= zeroDiv ? {i_A, 32'hFFFF_FFFF} : {32'd0, i_Op[1] ? aMag : bMag};
               state <= zeroDiv ? FIX : CALC;
            end
         end else if (i_Cancel) begin
            state <= IDLE;
            cnt <= 5'd0;
         end else if (state == CALC) begin
            acc <= calcNext;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) state <= FIX;
         end else if (cnt == 5'd0) begin
            acc <= fixNext;
            cnt <= 5'd1;
         end else begin
            {o_Hi, o_Lo} <= acc;
            o_Done <= 1'b1;
            o_DivZero <= zeroPend;
            state <= IDLE;
            cnt <= 5'd0;
         end
      end
   end
endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset, named i_clk and i_rst.
REQ-002 i_clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 i_rst  in  1  synchronous active-high reset.
REQ-004 i_Start  in  1  EX-stage request to begin a mult/div; sampled only in IDLE.
REQ-005 i_Op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 i_A, i_B  in  32 each  operands (rs, rt); i_A is the dividend, i_B the divisor.
REQ-007 i_Cancel  in  1  pipeline flush of the issuing instruction; aborts the operation.
REQ-008 i_HiLoRead  in  1  mfhi/mflo in EX this cycle.
REQ-009 i_WrHi, i_WrLo, i_WrData  in  1,1,32  mthi/mtlo write port.
REQ-010 o_Hi, o_Lo  out  32 each  architectural HI/LO registers.
REQ-011 o_Busy  out  1  state != IDLE.
REQ-012 o_Stall  out  1  combinational pipeline hold request.
REQ-013 o_Done  out  1  one-cycle pulse when HI/LO take a new mult/div result.
REQ-014 o_DivZero  out  1  one-cycle pulse, coincident with o_Done, for div/divu with i_B == 0.

Function
REQ-015 The FSM SHALL have the states IDLE, CALC and FIX, with a 5-bit iteration counter.
REQ-016 IDLE & i_Start & !i_Cancel & i_B != 0 (or a mult op) SHALL latch operands and op, clear the counter, and go to CALC.
REQ-017 Signed ops SHALL latch |i_A|, |i_B| (32-bit unsigned magnitude) plus sign bits; unsigned ops latch the raw values.
REQ-018 CALC SHALL process one bit per cycle: shift-add for mult (64-bit product), restoring shift-subtract for div (32-bit quotient/remainder).
REQ-019 CALC SHALL go to FIX when the counter reaches 31, after exactly 32 cycles.
REQ-020 In FIX, signed mult SHALL negate the 64-bit product if the signs differ; signed div SHALL negate the quotient if the signs differ and negate the remainder if i_A was negative.
REQ-021 FIX SHALL write {HI,LO} (mult) or HI=remainder, LO=quotient (div), return to IDLE, and assert o_Done the following cycle.
REQ-022 Latency: the result SHALL be visible on o_Hi/o_Lo exactly 34 cycles after the edge that sampled i_Start, together with o_Done.
REQ-023 Divide by zero at start SHALL go from IDLE directly to FIX, then write HI=i_A, LO=32'hFFFFFFFF, and pulse o_Done and o_DivZero in the same cycle (2-cycle latency).
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0 (natural 32-bit wrap).
REQ-025 o_Stall SHALL equal o_Busy & (i_HiLoRead | i_Start | i_WrHi | i_WrLo); there SHALL be no stall in IDLE.
REQ-026 i_Start while busy SHALL be ignored; the pipeline holds it via o_Stall until IDLE.
REQ-027 i_WrHi/i_WrLo SHALL update HI/LO only in IDLE; while busy they are not applied.
REQ-028 i_Cancel in CALC or FIX SHALL return to IDLE next edge with HI/LO unchanged and no o_Done.
REQ-029 i_Cancel together with i_Start in IDLE: cancel SHALL win and the start is dropped.
REQ-030 i_Start in IDLE together with i_WrHi/i_WrLo: the write SHALL apply and the operation SHALL also start; its result later overwrites.

Reset
REQ-031 i_rst SHALL force IDLE, counter=0, o_Hi=o_Lo=0, o_Done=o_DivZero=0 and all internal operand registers=0.
REQ-032 Reset mid-CALC SHALL discard the operation; no o_Done SHALL follow.
REQ-033 o_Busy and o_Stall SHALL be 0 in the cycle after reset.

Verification
REQ-034 mult A=0xFFFFFFFF, B=2 -> after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu, same operands -> HI=1, LO=0xFFFFFFFE.
REQ-035 div A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 100/7 -> LO=14, HI=2.
REQ-036 divu A=5, B=0 -> 2 cycles later HI=5, LO=0xFFFFFFFF, o_Done=o_DivZero=1 for one cycle.
REQ-037 mult started, i_HiLoRead asserted at cycle 10 -> o_Stall=1 until IDLE; the read returns the new result.
REQ-038 Start, then i_Cancel at cycle 5 -> IDLE next cycle, HI/LO keep prior values (e.g. 0x1234/0x5678), no o_Done.
REQ-039 Start, then i_rst at cycle 20 -> HI=LO=0, o_Busy=0, no o_Done in the following 40 cycles.
